cbus_arbiter: RTL and testbench

- Shares one cache-line memory port (cbus) between N cache-side requesters.
- Default wiring: index 0 = icache refill, index 1 = dcache refill/writeback.
- Sits between the cache pair behind the MMU and the AXI bridge.
- Grants whole bursts: the owner holds the port from first beat to the beat flagged m_last.

---
 rtl/cbus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_cbus_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : Burst-granular arbiter that shares one cache-line memory port
//               among N cache-side requesters. Round-robin or fixed priority.
//               The owner keeps the port until the downstream flags its last
//               beat. Beat counts are checked against the requested length.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arbiter #(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N-1:0]              req_valid,
    input  logic [N-1:0]              req_is_write,
    input  logic [3*N-1:0]            req_size,
    input  logic [ADDR_W*N-1:0]       req_addr,
    input  logic [(DATA_W/8)*N-1:0]   req_strobe,
    input  logic [DATA_W*N-1:0]       req_data,
    input  logic [4*N-1:0]            req_len,
    output logic [N-1:0]              resp_ready,
    output logic [N-1:0]              resp_last,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      m_valid,
    output logic                      m_is_write,
    output logic [2:0]                m_size,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W/8-1:0]       m_strobe,
    output logic [DATA_W-1:0]         m_data,
    output logic [3:0]                m_len,
    input  logic                      m_ready,
    input  logic                      m_last,
    input  logic [DATA_W-1:0]         m_rdata,
    output logic                      busy,
    output logic [$clog2(N)-1:0]      owner,
    output logic                      protocol_err
);

    localparam int         c_OW      = $clog2(N);
    localparam int         c_SW      = DATA_W / 8;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;
    localparam logic [4:0] c_CNT_MAX = 5'd31;

    logic [0:0]        r_state;
    logic [c_OW-1:0]   r_owner;
    logic [c_OW-1:0]   r_rr_ptr;
    logic [4:0]        r_beat_cnt;
    logic              r_protocol_err;

    logic [c_OW-1:0]   w_winner;
    logic [c_OW-1:0]   w_next_ptr;
    logic              w_own_valid;
    logic              w_own_write;
    logic [2:0]        w_own_size;
    logic [ADDR_W-1:0] w_own_addr;
    logic [c_SW-1:0]   w_own_strobe;
    logic [DATA_W-1:0] w_own_data;
    logic [3:0]        w_own_len;
    logic              w_busy;
    logic              w_len_match;
    logic              w_err;

    generate
        if (RR) begin : g_rr
            logic w_hit;
            // First requester at or after the pointer, wrapping at N-1
            always_comb begin
                w_winner = '0;
                w_hit    = 1'b0;
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < N; j++) begin
                        if (!w_hit && req_valid[j] &&
                            ((int'(r_rr_ptr) + k == j) || (int'(r_rr_ptr) + k == j + N))) begin
                            w_winner = c_OW'(j);
                            w_hit    = 1'b1;
                        end
                    end
                end
            end
        end else begin : g_fixed
            // Highest requesting index wins
            always_comb begin
                w_winner = '0;
                for (int j = 0; j < N; j++) begin
                    if (req_valid[j]) begin
                        w_winner = c_OW'(j);
                    end
                end
            end
        end
    endgenerate

    // Select the owner's request fields
    always_comb begin
        w_own_valid  = 1'b0;
        w_own_write  = 1'b0;
        w_own_size   = '0;
        w_own_addr   = '0;
        w_own_strobe = '0;
        w_own_data   = '0;
        w_own_len    = '0;
        for (int j = 0; j < N; j++) begin
            if (r_owner == c_OW'(j)) begin
                w_own_valid  = req_valid[j];
                w_own_write  = req_is_write[j];
                w_own_size   = req_size[3*j +: 3];
                w_own_addr   = req_addr[ADDR_W*j +: ADDR_W];
                w_own_strobe = req_strobe[c_SW*j +: c_SW];
                w_own_data   = req_data[DATA_W*j +: DATA_W];
                w_own_len    = req_len[4*j +: 4];
            end
        end
    end

    assign w_busy      = (r_state == c_ST_BUSY);
    assign w_next_ptr  = (r_owner == c_OW'(N - 1)) ? '0 : r_owner + c_OW'(1);
    assign w_len_match = (r_beat_cnt == {1'b0, w_own_len});
    // A final beat must land on the requested length; a non-final beat must not
    assign w_err       = w_busy && m_ready && (m_last ? !w_len_match : w_len_match);

    // Drive the downstream port and the owner's response lane while BUSY
    always_comb begin
        m_valid    = 1'b0;
        m_is_write = 1'b0;
        m_size     = '0;
        m_addr     = '0;
        m_strobe   = '0;
        m_data     = '0;
        m_len      = '0;
        resp_ready = '0;
        resp_last  = '0;
        resp_data  = '0;
        if (w_busy) begin
            m_valid    = w_own_valid;
            m_is_write = w_own_write;
            m_size     = w_own_size;
            m_addr     = w_own_addr;
            m_strobe   = w_own_strobe;
            m_data     = w_own_data;
            m_len      = w_own_len;
            resp_data  = m_rdata;
            for (int j = 0; j < N; j++) begin
                if (r_owner == c_OW'(j)) begin
                    resp_ready[j] = m_ready;
                    resp_last[j]  = m_last;
                end
            end
        end
    end

    // Grant/release state machine with beat counting and error pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= c_ST_IDLE;
            r_owner        <= '0;
            r_rr_ptr       <= '0;
            r_beat_cnt     <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_protocol_err <= w_err;
            case (r_state)
                c_ST_IDLE: begin
                    if (|req_valid) begin
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (m_ready && (r_beat_cnt != c_CNT_MAX)) begin
                        r_beat_cnt <= r_beat_cnt + 5'd1;
                    end
                    // Only the downstream last beat ends a burst
                    if (m_ready && m_last) begin
                        r_state <= c_ST_IDLE;
                        if (RR) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy         = w_busy;
    assign owner        = r_owner;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Scoreboard bench for cbus_arbiter. Requester and memory models
//               drive a 3-port round-robin instance; a monitor pops expected
//               bursts and checks grants, muxing, responses and beat errors.
//               A 2-port fixed-priority instance gets a short directed run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;

    localparam int N = 3;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] wbase;
        int          actual;
    } burst_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [N-1:0]  req_valid, req_is_write, resp_ready, resp_last;
    logic [3*N-1:0]  req_size;
    logic [32*N-1:0] req_addr, req_data;
    logic [4*N-1:0]  req_strobe, req_len;
    logic [31:0]   resp_data, m_addr, m_data, m_rdata;
    logic          m_valid, m_is_write, m_ready, m_last, busy, protocol_err;
    logic [2:0]    m_size;
    logic [3:0]    m_strobe, m_len;
    logic [1:0]    owner;

    cbus_arbiter #(.N(N), .ADDR_W(32), .DATA_W(32), .RR(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_is_write(req_is_write),
        .req_size(req_size), .req_addr(req_addr), .req_strobe(req_strobe),
        .req_data(req_data), .req_len(req_len), .resp_ready(resp_ready),
        .resp_last(resp_last), .resp_data(resp_data), .m_valid(m_valid),
        .m_is_write(m_is_write), .m_size(m_size), .m_addr(m_addr), .m_strobe(m_strobe),
        .m_data(m_data), .m_len(m_len), .m_ready(m_ready), .m_last(m_last),
        .m_rdata(m_rdata), .busy(busy), .owner(owner), .protocol_err(protocol_err)
    );

    // Fixed-priority instance with single-beat bursts always accepted
    logic [1:0]  f_req_valid, f_resp_ready, f_resp_last;
    logic [1:0]  f_zero2 = '0;
    logic [5:0]  f_zero6 = '0;
    logic [7:0]  f_zero8 = '0;
    logic [63:0] f_zero64 = '0;
    logic [31:0] f_resp_data, f_m_addr, f_m_data;
    logic        f_m_valid, f_m_is_write, f_busy, f_owner, f_protocol_err;
    logic [2:0]  f_m_size;
    logic [3:0]  f_m_strobe, f_m_len;

    cbus_arbiter #(.N(2), .ADDR_W(32), .DATA_W(32), .RR(1'b0)) u_dut_fp (
        .clk(clk), .resetn(resetn), .req_valid(f_req_valid), .req_is_write(f_zero2),
        .req_size(f_zero6), .req_addr(f_zero64), .req_strobe(f_zero8),
        .req_data(f_zero64), .req_len(f_zero8), .resp_ready(f_resp_ready),
        .resp_last(f_resp_last), .resp_data(f_resp_data), .m_valid(f_m_valid),
        .m_is_write(f_m_is_write), .m_size(f_m_size), .m_addr(f_m_addr),
        .m_strobe(f_m_strobe), .m_data(f_m_data), .m_len(f_m_len), .m_ready(1'b1),
        .m_last(1'b1), .m_rdata(32'h0), .busy(f_busy), .owner(f_owner),
        .protocol_err(f_protocol_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rdata_fn(logic [31:0] a, int beat);
        return 32'hA0 + {8'h00, a[15:0], 8'h00} + 32'(beat);
    endfunction

    // Round-robin reference: first requesting index at or after ptr, wrapping
    function automatic int first_from(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Requester and memory model state
    burst_t rq[N];
    bit     rq_active[N];
    int     rq_beat[N];
    int     rr_pulses[N];
    int     sl_beat;
    int     ready_pct;
    burst_t exp_q[$];
    int     grant_log[$];
    int     err_pulses;

    function automatic burst_t mk(int i, bit wr, logic [31:0] a, int len, logic [3:0] s,
                                  logic [31:0] wb, int actual);
        burst_t b;
        b.idx = i; b.wr = wr; b.addr = a; b.len = 4'(len); b.size = 3'd2;
        b.strb = s; b.wbase = wb; b.actual = actual;
        return b;
    endfunction

    function automatic burst_t rand_burst(int i);
        burst_t b;
        logic [31:0] t;
        t = $urandom;
        b.idx = i; b.wr = 1'($urandom % 2); b.addr = {t[31:2], 2'b00};
        b.len = 4'($urandom % 16); b.size = 3'($urandom % 8);
        b.strb = 4'($urandom % 16); b.wbase = $urandom;
        b.actual = ($urandom % 8 == 0) ? int'($urandom_range(1, 17)) : int'(b.len) + 1;
        return b;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rq_active[i];
            req_is_write[i]      = rq[i].wr;
            req_size[3*i +: 3]   = rq[i].size;
            req_addr[32*i +: 32] = rq[i].addr;
            req_data[32*i +: 32] = rq[i].wbase + 32'(rq_beat[i]);
            req_len[4*i +: 4]    = rq[i].len;
            req_strobe[4*i +: 4] = rq[i].strb;
        end
    endtask

    task automatic issue(burst_t b);
        rq[b.idx]        = b;
        rq_beat[b.idx]   = 0;
        rq_active[b.idx] = 1'b1;
        exp_q.push_back(b);
        drive_bus();
    endtask

    // Memory model: random stalls, m_last after the planned number of beats
    task automatic slave_drive();
        int o;
        if (busy) begin
            o = int'(owner);
            if (o >= N) o = 0;
            m_ready = ($urandom_range(0, 99) < ready_pct);
            m_last  = m_ready && (sl_beat == rq[o].actual - 1);
            m_rdata = rdata_fn(rq[o].addr, sl_beat);
        end else begin
            m_ready = 1'($urandom % 2);
            m_last  = 1'($urandom % 2);
            m_rdata = $urandom;
        end
    endtask

    task automatic step();
        logic         s_busy;
        logic [N-1:0] s_rr, s_rl;
        @(negedge clk);
        s_busy = busy; s_rr = resp_ready; s_rl = resp_last;
        @(posedge clk); #1;
        if (s_busy && m_ready) sl_beat = m_last ? 0 : sl_beat + 1;
        for (int i = 0; i < N; i++) begin
            if (s_rr[i]) begin
                rq_beat[i]++;
                rr_pulses[i]++;
                if (s_rl[i]) rq_active[i] = 1'b0;
            end
        end
        drive_bus();
        slave_drive();
    endtask

    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (rq_active[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(int budget, string name);
        int c = 0;
        while ((any_active() || busy) && c < budget) begin
            step();
            c++;
        end
        chk(name, c < budget, 1);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            rq_active[i] = 1'b0; rq_beat[i] = 0;
            rq[i] = mk(i, 1'b0, 32'h0, 0, 4'h0, 32'h0, 1);
        end
        exp_q.delete();
        grant_log.delete();
        sl_beat = 0; m_ready = 1'b0; m_last = 1'b0; m_rdata = '0;
        drive_bus();
    endtask

    // Assert reset, check outputs before any clock edge, then release
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_resp_last", resp_last, 0);
        chk("rst_owner", owner, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_fp_busy", f_busy, 0);
        clear_bench();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Scoreboard monitor
    int     mon_ptr, mon_beat, mon_pred;
    bit     mon_cur_v, mon_exp_err, mon_prev_busy, mon_last_hs, mon_pred_v, mon_found;
    burst_t mon_cur;
    logic [N-1:0] mon_e;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_ptr = 0; mon_cur_v = 0; mon_exp_err = 0;
            mon_prev_busy = 0; mon_last_hs = 0; mon_pred_v = 0;
        end else begin
            if (protocol_err) err_pulses++;
            chk("protocol_err", protocol_err, mon_exp_err);
            mon_exp_err = 0;
            if (mon_last_hs) chk("idle_gap_busy", busy, 0);
            mon_last_hs = 0;
            if (!busy) begin
                chk("idle_m_valid", m_valid, 0);
                chk("idle_resp_ready", resp_ready, 0);
                chk("idle_resp_last", resp_last, 0);
                mon_pred_v = |req_valid;
                mon_pred   = first_from(req_valid, mon_ptr);
            end else begin
                if (!mon_prev_busy) begin
                    grant_log.push_back(int'(owner));
                    chk("grant_had_request", mon_pred_v, 1);
                    chk("grant_owner", owner, 64'(mon_pred));
                    mon_found = 0;
                    foreach (exp_q[k]) begin
                        if (!mon_found && exp_q[k].idx == mon_pred) begin
                            mon_cur = exp_q[k];
                            exp_q.delete(k);
                            mon_found = 1;
                        end
                    end
                    chk("grant_expected_burst", mon_found, 1);
                    mon_cur_v = mon_found;
                    mon_beat  = 0;
                end
                if (mon_cur_v) begin
                    chk("owner", owner, 64'(mon_cur.idx));
                    chk("m_valid", m_valid, 1);
                    chk("m_is_write", m_is_write, mon_cur.wr);
                    chk("m_addr", m_addr, mon_cur.addr);
                    chk("m_size", m_size, mon_cur.size);
                    chk("m_strobe", m_strobe, mon_cur.strb);
                    chk("m_len", m_len, mon_cur.len);
                    chk("m_data", m_data, mon_cur.wbase + 32'(mon_beat));
                    mon_e = '0;
                    mon_e[mon_cur.idx] = m_ready;
                    chk("resp_ready", resp_ready, mon_e);
                    mon_e = '0;
                    mon_e[mon_cur.idx] = m_last;
                    chk("resp_last", resp_last, mon_e);
                    if (m_ready) begin
                        if (!mon_cur.wr) chk("resp_data", resp_data, rdata_fn(mon_cur.addr, mon_beat));
                        mon_exp_err = m_last ? (mon_beat != int'(mon_cur.len))
                                             : (mon_beat == int'(mon_cur.len));
                        mon_beat++;
                        if (m_last) begin
                            mon_last_hs = 1;
                            mon_ptr     = (mon_cur.idx + 1) % N;
                            mon_cur_v   = 0;
                        end
                    end
                end
            end
            mon_prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int p0, e0, n_iss[N], fg, c;
        int exp_rr[4] = '{0, 1, 0, 1};
        ready_pct = 100; err_pulses = 0; f_req_valid = 2'b00;
        for (int i = 0; i < N; i++) rr_pulses[i] = 0;
        do_reset();

        // Single read burst on requester 0
        p0 = rr_pulses[0];
        issue(mk(0, 1'b0, 32'h1FC00000, 3, 4'h0, 32'h0, 4));
        step();
        chk("grant_latency_m_valid", m_valid, 1);
        chk("grant_latency_m_addr", m_addr, 32'h1FC00000);
        wait_done(50, "single_read_done");
        chk("single_read_pulses0", rr_pulses[0] - p0, 4);
        chk("single_read_pulses1", rr_pulses[1], 0);

        // Round-robin between 0 and 1, single-beat bursts
        do_reset();
        n_iss[0] = 1; n_iss[1] = 1;
        issue(mk(0, 1'b0, 32'h100, 0, 4'h0, 32'h0, 1));
        issue(mk(1, 1'b0, 32'h200, 0, 4'h0, 32'h0, 1));
        c = 0;
        while ((any_active() || busy) && c < 40) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!rq_active[i] && n_iss[i] < 2) begin
                    issue(mk(i, 1'b0, 32'h300 + 32'(i), 0, 4'h0, 32'h0, 1));
                    n_iss[i]++;
                end
            end
            c++;
        end
        chk("rr_done", c < 40, 1);
        chk("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4)
            for (int k = 0; k < 4; k++) chk("rr_grant_order", grant_log[k], exp_rr[k]);

        // Write burst on requester 1
        e0 = err_pulses;
        issue(mk(1, 1'b1, 32'h80001000, 1, 4'hF, 32'hDEAD0000, 2));
        wait_done(50, "write_done");
        chk("write_no_err", err_pulses - e0, 0);

        // Early m_last: length 1 but one beat
        e0 = err_pulses;
        issue(mk(0, 1'b0, 32'h4000, 1, 4'h0, 32'h0, 1));
        wait_done(50, "mismatch_done");
        step(); step();
        chk("mismatch_err_pulses", err_pulses - e0, 1);

        // Randomized traffic with stalls and occasional length mismatches
        ready_pct = 70;
        for (int cy = 0; cy < 1500; cy++) begin
            step();
            for (int i = 0; i < N; i++)
                if (!rq_active[i] && $urandom_range(0, 99) < 30) issue(rand_burst(i));
        end
        wait_done(800, "random_drain");
        ready_pct = 100;

        // Reset mid-burst; pointer is parked at 2 first so its restart shows
        issue(mk(1, 1'b0, 32'h500, 0, 4'h0, 32'h0, 1));
        wait_done(20, "pre_reset_done");
        issue(mk(0, 1'b0, 32'h600, 7, 4'h0, 32'h0, 8));
        c = 0;
        while (rq_beat[0] < 2 && c < 30) begin step(); c++; end
        chk("reset_burst_reached_beat2", c < 30, 1);
        chk("reset_pre_busy", busy, 1);
        do_reset();
        issue(mk(1, 1'b0, 32'h700, 0, 4'h0, 32'h0, 1));
        issue(mk(2, 1'b0, 32'h800, 0, 4'h0, 32'h0, 1));
        step();
        chk("post_reset_grant_busy", busy, 1);
        chk("post_reset_grant_owner", owner, 1);
        wait_done(30, "post_reset_done");

        // Fixed priority instance
        @(posedge clk); #1;
        f_req_valid = 2'b11;
        fg = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (f_busy) begin
                fg++;
                chk("fp_owner", f_owner, 1);
                chk("fp_resp_ready", f_resp_ready, 2'b10);
            end
        end
        chk("fp_grant_count", fg >= 4, 1);
        c = 0;
        @(negedge clk);
        while (!f_busy && c < 10) begin @(negedge clk); c++; end
        chk("fp_align", f_busy, 1);
        @(posedge clk); #1;
        f_req_valid = 2'b01;
        @(negedge clk);
        chk("fp_idle_gap", f_busy, 0);
        @(negedge clk);
        chk("fp_low_busy", f_busy, 1);
        chk("fp_low_owner", f_owner, 0);
        chk("fp_low_resp_ready", f_resp_ready, 2'b01);
        @(posedge clk); #1;
        f_req_valid = 2'b00;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
